// File: rtl/switch_segment_io_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : io_pkg
//  Brief    : Shared constants, read-source enum and address-map helper for
//             the switch / seven-segment I/O peripheral.
//  Revision : 1.0  initial release
// ============================================================================
package io_pkg;

  // Default bus geometry and address map (top of a 5-bit address space)
  localparam int c_WORD_W    = 8;
  localparam int c_OP_W      = 3;
  localparam int c_ADDR_W    = c_WORD_W - c_OP_W;
  localparam int c_SEG_BASE  = 24;
  localparam int c_SW_BASE   = 28;
  localparam int c_STAT_ADDR = 31;

  // Which register class the current mar selects
  typedef enum logic [1:0] {
    SRC_SEG  = 2'd0,
    SRC_SW   = 2'd1,
    SRC_STAT = 2'd2,
    SRC_NONE = 2'd3
  } rd_src_e;

  // True when address windows [a_lo, a_lo+a_n) and [b_lo, b_lo+b_n) share a slot
  function automatic bit ranges_overlap(input int a_lo, input int a_n,
                                        input int b_lo, input int b_n);
    return (a_lo <= b_lo + b_n - 1) && (b_lo <= a_lo + a_n - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/switch_segment_io_if.sv
`default_nettype none
// ============================================================================
//  Module   : switch_segment_io_if
//  Brief    : Sequencer control strobes for a MAR/MDR bus peripheral.
//             The shared tri-state data bus is carried separately.
//  Revision : 1.0  initial release
// ============================================================================
interface switch_segment_io_if;
  logic load_MAR;
  logic load_MDR;
  logic CS;
  logic R_NW;
  logic MDR_bus;

  modport master (output load_MAR, load_MDR, CS, R_NW, MDR_bus);
  modport slave  (input  load_MAR, load_MDR, CS, R_NW, MDR_bus);
endinterface
`default_nettype wire

// File: rtl/switch_segment_io_sw_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : sw_debounce
//  Brief    : Two-flop synchroniser plus consecutive-difference counter for one
//             switch bank. o_changed is high in the cycle whose closing edge
//             loads the new debounced value, so a status flag set from it
//             lands on the same edge as o_deb.
//  Revision : 1.0  initial release
// ============================================================================
module sw_debounce
  import io_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int DEB_CYC = 4
) (
  input  wire logic             clock,
  input  wire logic             reset,
  input  wire logic [WIDTH-1:0] i_raw,
  output logic      [WIDTH-1:0] o_deb,
  output logic                  o_changed
);

  localparam int                 c_CNT_W    = $clog2(DEB_CYC + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEB_CYC - 1);

  logic [WIDTH-1:0]   r_sync1;
  logic [WIDTH-1:0]   r_sync2;
  logic [WIDTH-1:0]   r_deb;
  logic [c_CNT_W-1:0] r_cnt;
  logic               w_fire;

  // Accept the synchronised value once it has differed for DEB_CYC cycles
  assign w_fire = (r_sync2 != r_deb) && (r_cnt == c_CNT_LAST);

  // Synchroniser, difference counter (saturating) and debounced register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_deb   <= '0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_deb) begin
        r_cnt <= '0;
      end else if (w_fire) begin
        r_deb <= r_sync2;
        r_cnt <= '0;
      end else if (r_cnt < c_CNT_LAST) begin
        r_cnt <= r_cnt + c_CNT_W'(1);
      end
    end
  end

  assign o_deb     = r_deb;
  assign o_changed = w_fire;

endmodule
`default_nettype wire

// File: rtl/switch_segment_io.sv
`default_nettype none
// ============================================================================
//  Module   : switch_segment_io
//  Brief    : Memory-mapped switch / seven-segment / change-status peripheral
//             on the MAR/MDR system bus with a tri-state data driver.
//  Revision : 1.0  initial release
// ============================================================================
module switch_segment_io
  import io_pkg::*;
#(
  parameter int WORD_W    = c_WORD_W,
  parameter int OP_W      = c_OP_W,
  parameter int N_SW      = 2,
  parameter int N_SEG     = 4,
  parameter int DEB_CYC   = 4,
  parameter int SEG_BASE  = c_SEG_BASE,
  parameter int SW_BASE   = c_SW_BASE,
  parameter int STAT_ADDR = c_STAT_ADDR
) (
  input  wire logic                    clock,
  input  wire logic                    reset,
  switch_segment_io_if.slave           bus,
  inout  wire       [WORD_W-1:0]       sysbus,
  input  wire logic [N_SW*WORD_W-1:0]  switches,
  output logic      [N_SEG*WORD_W-1:0] hex
);

  localparam int c_AW     = WORD_W - OP_W;
  localparam int c_SEG_IW = (N_SEG > 1) ? $clog2(N_SEG) : 1;
  localparam int c_SW_IW  = (N_SW > 1) ? $clog2(N_SW) : 1;

  // Reject parameter sets that would give an ambiguous or unreachable map
  if (N_SW < 1 || N_SW > WORD_W) begin : g_bad_nsw
    $error("switch_segment_io: N_SW must be 1..WORD_W");
  end
  if (DEB_CYC < 1) begin : g_bad_deb
    $error("switch_segment_io: DEB_CYC must be >= 1");
  end
  if (SEG_BASE == 0 || SW_BASE == 0 || STAT_ADDR == 0) begin : g_bad_zero
    $error("switch_segment_io: address 0 must stay unmapped");
  end
  if (ranges_overlap(SEG_BASE, N_SEG, SW_BASE, N_SW) ||
      ranges_overlap(SEG_BASE, N_SEG, STAT_ADDR, 1) ||
      ranges_overlap(SW_BASE, N_SW, STAT_ADDR, 1)) begin : g_bad_overlap
    $error("switch_segment_io: address ranges overlap");
  end
  if (SEG_BASE + N_SEG > (1 << c_AW) || SW_BASE + N_SW > (1 << c_AW) ||
      STAT_ADDR >= (1 << c_AW)) begin : g_bad_range
    $error("switch_segment_io: address map exceeds ADDR_W");
  end

  logic [c_AW-1:0]                r_mar;
  logic [WORD_W-1:0]              r_mdr;
  logic [N_SEG-1:0][WORD_W-1:0]   r_seg;
  logic [N_SW-1:0]                r_status;
  logic [N_SW-1:0][WORD_W-1:0]    w_deb;
  logic [N_SW-1:0]                w_changed;
  logic [N_SW-1:0]                w_clr;
  rd_src_e                        w_src;
  logic [c_SEG_IW-1:0]            w_seg_idx;
  logic [c_SW_IW-1:0]             w_sw_idx;
  logic [WORD_W-1:0]              w_rd_val;
  logic                           w_hit;
  logic                           w_cs_act;

  // One debouncer per switch bank, bank 0 on the LSBs
  for (genvar b = 0; b < N_SW; b++) begin : g_bank
    sw_debounce #(
      .WIDTH   (WORD_W),
      .DEB_CYC (DEB_CYC)
    ) u_deb (
      .clock     (clock),
      .reset     (reset),
      .i_raw     (switches[b*WORD_W +: WORD_W]),
      .o_deb     (w_deb[b]),
      .o_changed (w_changed[b])
    );
  end

  // Address decode: classify mar and derive the index inside its window
  always_comb begin
    w_src     = SRC_NONE;
    w_seg_idx = '0;
    w_sw_idx  = '0;
    if (int'(r_mar) >= SEG_BASE && int'(r_mar) < SEG_BASE + N_SEG) begin
      w_src     = SRC_SEG;
      w_seg_idx = c_SEG_IW'(int'(r_mar) - SEG_BASE);
    end else if (int'(r_mar) >= SW_BASE && int'(r_mar) < SW_BASE + N_SW) begin
      w_src    = SRC_SW;
      w_sw_idx = c_SW_IW'(int'(r_mar) - SW_BASE);
    end else if (int'(r_mar) == STAT_ADDR) begin
      w_src = SRC_STAT;
    end
  end

  // Read-data mux; status is zero-extended to the word width
  always_comb begin
    w_rd_val = '0;
    case (w_src)
      SRC_SEG:  w_rd_val = r_seg[w_seg_idx];
      SRC_SW:   w_rd_val = w_deb[w_sw_idx];
      SRC_STAT: w_rd_val = WORD_W'(r_status);
      default:  w_rd_val = '0;
    endcase
  end

  assign w_hit    = (w_src != SRC_NONE);
  // CS only acts when neither register load claims the edge
  assign w_cs_act = bus.CS && !bus.load_MAR && !bus.load_MDR;
  assign w_clr    = (w_cs_act && !bus.R_NW && w_src == SRC_STAT) ?
                    r_mdr[N_SW-1:0] : '0;

  // Bus-side registers: one action per edge, load_MAR > load_MDR > CS
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_mar <= '0;
      r_mdr <= '0;
      r_seg <= '0;
    end else if (bus.load_MAR) begin
      r_mar <= sysbus[c_AW-1:0];
    end else if (bus.load_MDR) begin
      r_mdr <= sysbus;
    end else if (bus.CS) begin
      if (bus.R_NW) begin
        if (w_hit) r_mdr <= w_rd_val;
      end else if (w_src == SRC_SEG) begin
        r_seg[w_seg_idx] <= r_mdr;
      end
    end
  end

  // Change status: write-1-to-clear, a same-edge debounce set wins
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_status <= '0;
    end else begin
      r_status <= (r_status & ~w_clr) | w_changed;
    end
  end

  assign sysbus = (bus.MDR_bus && w_hit) ? r_mdr : {WORD_W{1'bz}};
  assign hex    = r_seg;

endmodule
`default_nettype wire

// File: tb/tb_switch_segment_io.sv
`default_nettype none
// ============================================================================
//  Module   : tb_switch_segment_io
//  Brief    : Scoreboard bench for switch_segment_io with default parameters.
//  Revision : 1.0  initial release
// ============================================================================
module tb_switch_segment_io;

  localparam int K_BUS = 0;
  localparam int K_HEX = 1;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] switches;
  wire  [31:0] hex;
  wire  [7:0]  sysbus;
  logic        tb_en;
  logic [7:0]  tb_val;

  switch_segment_io_if bus_if ();

  assign sysbus = tb_en ? tb_val : 8'bz;

  switch_segment_io dut (
    .clock    (clock),
    .reset    (reset),
    .bus      (bus_if),
    .sysbus   (sysbus),
    .switches (switches),
    .hex      (hex)
  );

  always #5 clock = ~clock;

  // Scoreboard
  int          kind_q[$];
  logic [31:0] exp_q[$];
  string       name_q[$];
  logic        sample_req = 1'b0;
  int          checks = 0;
  int          errors = 0;

  // Monitor: observe the state just after each edge that stimulus flagged
  initial begin
    forever begin
      @(posedge clock);
      #2;
      if (sample_req) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL monitor: sample with empty expect queue");
        end else begin
          int          k;
          logic [31:0] e;
          logic [31:0] obs;
          string       n;
          k   = kind_q.pop_front();
          e   = exp_q.pop_front();
          n   = name_q.pop_front();
          obs = (k == K_BUS) ? {24'h0, sysbus} : hex;
          checks++;
          if (obs !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, obs, e);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic expect_out(input int kind, input logic [31:0] val, input string name);
    kind_q.push_back(kind);
    exp_q.push_back(val);
    name_q.push_back(name);
    sample_req = 1'b1;
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
    sample_req = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic load_mar(input logic [7:0] a);
    tb_en = 1'b1; tb_val = a; bus_if.load_MAR = 1'b1;
    tick();
    bus_if.load_MAR = 1'b0; tb_en = 1'b0;
  endtask

  task automatic load_mdr(input logic [7:0] v);
    tb_en = 1'b1; tb_val = v; bus_if.load_MDR = 1'b1;
    tick();
    bus_if.load_MDR = 1'b0; tb_en = 1'b0;
  endtask

  task automatic write_reg();
    bus_if.CS = 1'b1; bus_if.R_NW = 1'b0;
    tick();
    bus_if.CS = 1'b0;
  endtask

  task automatic write_hex(input logic [31:0] e, input string name);
    bus_if.CS = 1'b1; bus_if.R_NW = 1'b0;
    expect_out(K_HEX, e, name);
    tick();
    bus_if.CS = 1'b0;
  endtask

  task automatic read_reg(input logic [7:0] e, input string name);
    bus_if.CS = 1'b1; bus_if.R_NW = 1'b1; bus_if.MDR_bus = 1'b1;
    expect_out(K_BUS, {24'h0, e}, name);
    tick();
    bus_if.CS = 1'b0; bus_if.R_NW = 1'b0; bus_if.MDR_bus = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    switches = 16'h0000;
    tb_en = 1'b0; tb_val = 8'h00;
    bus_if.load_MAR = 1'b0; bus_if.load_MDR = 1'b0;
    bus_if.CS = 1'b0; bus_if.R_NW = 1'b0; bus_if.MDR_bus = 1'b0;

    // Reset state
    expect_out(K_HEX, 32'h0, "reset_hex");
    tick();
    reset = 1'b0;
    tick();
    load_mar(8'd31);
    read_reg(8'h00, "reset_stat");

    // Write / readback of segment register 1, then register 3
    load_mar(8'd25);
    load_mdr(8'hA5);
    write_hex(32'h0000_A500, "wr_seg1_hex");
    load_mdr(8'h00);
    read_reg(8'hA5, "rd_seg1");
    load_mar(8'd27);
    load_mdr(8'h5A);
    write_hex(32'h5A00_A500, "wr_seg3_hex");

    // 3-cycle glitch on bank 0 is rejected
    switches[7:0] = 8'h3C;
    idle(3);
    switches[7:0] = 8'h00;
    idle(8);
    load_mar(8'd28);
    read_reg(8'h00, "glitch_sw0");
    load_mar(8'd31);
    read_reg(8'h00, "glitch_stat");

    // Stable change: continuous read of bank 0; the edge-6 read returns old deb
    load_mar(8'd28);
    switches[7:0] = 8'h3C;
    bus_if.CS = 1'b1; bus_if.R_NW = 1'b1; bus_if.MDR_bus = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      expect_out(K_BUS, (i == 7) ? 32'h3C : 32'h00, $sformatf("deb_edge%0d", i));
      tick();
    end
    bus_if.CS = 1'b0; bus_if.R_NW = 1'b0; bus_if.MDR_bus = 1'b0;
    load_mar(8'd31);
    read_reg(8'h01, "deb_stat");

    // Bank 1 debounces -> both status bits set
    switches[15:8] = 8'h0F;
    idle(8);
    read_reg(8'h03, "stat_both");

    // W1C of both bits on the edge bank 1 debounces again: set wins
    load_mdr(8'h03);
    switches[15:8] = 8'h00;
    idle(5);
    write_reg();
    read_reg(8'h02, "race_stat");
    load_mdr(8'h02);
    write_reg();
    read_reg(8'h00, "w1c_stat");

    // Unmapped access and priority
    load_mar(8'd25);
    read_reg(8'hA5, "rd_seg1_again");
    load_mar(8'd5);
    tb_en = 1'b1; tb_val = 8'h00;
    bus_if.CS = 1'b1; bus_if.R_NW = 1'b1; bus_if.MDR_bus = 1'b1;
    expect_out(K_BUS, 32'h00, "unmapped_rd_bus");
    tick();
    bus_if.R_NW = 1'b0; bus_if.MDR_bus = 1'b0;
    expect_out(K_HEX, 32'h5A00_A500, "unmapped_wr_hex");
    tick();
    bus_if.CS = 1'b0; tb_en = 1'b0;
    load_mar(8'd25);
    bus_if.MDR_bus = 1'b1;
    expect_out(K_BUS, 32'hA5, "mdr_kept");
    tick();
    bus_if.MDR_bus = 1'b0;
    load_mdr(8'h77);
    tb_en = 1'b1; tb_val = 8'd24;
    bus_if.load_MAR = 1'b1; bus_if.CS = 1'b1; bus_if.R_NW = 1'b0;
    expect_out(K_HEX, 32'h5A00_A500, "pri_mar_hex");
    tick();
    bus_if.load_MAR = 1'b0; bus_if.CS = 1'b0; tb_en = 1'b0;
    bus_if.MDR_bus = 1'b1;
    expect_out(K_BUS, 32'h77, "pri_mar_mdr");
    tick();
    bus_if.MDR_bus = 1'b0;
    tb_en = 1'b1; tb_val = 8'h11;
    bus_if.load_MDR = 1'b1; bus_if.CS = 1'b1; bus_if.R_NW = 1'b0;
    expect_out(K_HEX, 32'h5A00_A500, "pri_mdr_hex");
    tick();
    bus_if.load_MDR = 1'b0; bus_if.CS = 1'b0; tb_en = 1'b0;
    write_hex(32'h5A00_A511, "seg0_wr");

    // Reset in the middle of a debounce with MDR_bus high at a switch address
    load_mar(8'd28);
    read_reg(8'h3C, "pre_rst_sw0");
    switches = 16'h5581;
    idle(3);
    bus_if.MDR_bus = 1'b1;
    expect_out(K_BUS, 32'h3C, "pre_rst_bus");
    tick();
    reset = 1'b1;
    tb_en = 1'b1; tb_val = 8'h00;
    expect_out(K_BUS, 32'h00, "rst_bus_z");
    tick();
    expect_out(K_HEX, 32'h0, "rst_hex");
    tick();
    reset = 1'b0;
    bus_if.MDR_bus = 1'b0;
    tb_val = 8'd28; bus_if.load_MAR = 1'b1;
    tick();
    bus_if.load_MAR = 1'b0; tb_en = 1'b0;
    bus_if.CS = 1'b1; bus_if.R_NW = 1'b1; bus_if.MDR_bus = 1'b1;
    for (int i = 2; i <= 7; i++) begin
      expect_out(K_BUS, (i == 7) ? 32'h81 : 32'h00, $sformatf("rst_deb_edge%0d", i));
      tick();
    end
    bus_if.CS = 1'b0; bus_if.R_NW = 1'b0; bus_if.MDR_bus = 1'b0;
    load_mar(8'd31);
    read_reg(8'h03, "rst_stat");

    idle(2);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expected responses never observed, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
